// File: rtl/spi_slave_frame_rx_if.sv
// rtl/spi_slave_frame_rx_if.sv - SPI pin bundle between the frame master and the frame receiver
interface spi_slave_frame_rx_if;
  logic sclk;
  logic mosi;
  logic ss;
  logic miso;

  modport master (output sclk, output mosi, output ss, input miso);
  modport slave  (input sclk, input mosi, input ss, output miso);
endinterface

// File: rtl/spi_slave_frame_rx.sv
// rtl/spi_slave_frame_rx.sv - SPI mode-0 slave receiving the 14-bit counter frame, with miso loopback
module spi_slave_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter bit CHECK_PAD   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_slave_frame_rx_if.slave   spi,
  output logic [13:0]           o_data,
  output logic                  o_valid,
  output logic                  o_frame_err
);

  typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;

  state_t                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
  logic                   r_sclk_prev, r_ss_prev;
  logic [4:0]             r_cnt;
  logic [15:0]            r_shift, r_tx;
  logic [13:0]            r_loop, r_data;
  logic                   r_miso, r_valid, r_err;

  logic w_sclk_s, w_mosi_s, w_ss_s;
  logic w_sclk_rise, w_sclk_fall, w_ss_rise;
  logic w_start, w_shift_in, w_shift_out, w_check, w_frame_ok;
  logic [15:0] w_tx_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi.ss};
      r_sclk_prev <= w_sclk_s;
      r_ss_prev   <= w_ss_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_ss_rise   = w_ss_s & ~r_ss_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // IDLE enters RX on the ss level, so a select that dropped during CHECK is not lost
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_ss_s)   w_state_next = RX;
      RX:      if (w_ss_rise) w_state_next = CHECK;
      CHECK:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_start     = (r_state == IDLE) && !w_ss_s;
    w_shift_in  = (r_state == RX) && w_sclk_rise && !w_ss_rise;
    w_shift_out = (r_state == RX) && w_sclk_fall && !w_ss_rise;
    w_check     = (r_state == CHECK);
    w_frame_ok  = (r_cnt == 5'd16) && ((CHECK_PAD == 1'b0) || (r_shift[15:14] == 2'b00));
    w_tx_load   = {2'b00, r_loop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_tx    <= '0;
      r_loop  <= '0;
      r_data  <= '0;
      r_miso  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_check && w_frame_ok;
      r_err   <= w_check && !w_frame_ok;
      if (w_start) begin
        r_cnt   <= '0;
        r_shift <= '0;
        r_tx    <= w_tx_load;
        r_miso  <= w_tx_load[15];
      end
      if (w_shift_in) begin
        r_shift <= {r_shift[14:0], w_mosi_s};
        if (r_cnt != 5'd17) r_cnt <= r_cnt + 5'd1;
      end
      // zero fill means miso falls to 0 once all 16 loopback bits are out
      if (w_shift_out) begin
        r_tx   <= {r_tx[14:0], 1'b0};
        r_miso <= r_tx[14];
      end
      if (w_check) begin
        r_tx   <= '0;
        r_miso <= 1'b0;
        if (w_frame_ok) begin
          r_data <= r_shift[13:0];
          r_loop <= r_shift[13:0];
        end
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_err;
  assign spi.miso    = r_miso;

endmodule
